irq_sequencer: RTL
==================

// Module: irq_sequencer
// PURPOSE
//   CPU-side responder for the interrupt controller's IRQ/ADDR/IACK handshake.
//   Sits beside the mips core: accepts the level IRQ and handler vector,
//   waits for a safe instruction boundary, saves the return PC (EPC),
//   redirects fetch to the handler and pulses IACK. On return-from-interrupt
//   (eret) it redirects fetch back to EPC. No nesting: IRQ is ignored in-handler.
// PARAMETERS
//   IE_RESET     1  value of interrupt-enable after reset
//   COUNT_WIDTH  8  width of serviced-interrupt counter (saturating)
// PORTS
//   clk          in   1   system clock, all state on rising edge
//   rst          in   1   asynchronous, active-low reset
//   irq          in   1   level interrupt request from intc
//   irq_addr     in   32  handler vector from intc, valid while irq high
//   irq_ack      out  1   one-cycle acknowledge to intc
//   pc_next      in   32  PC the core would fetch next (return address)
//   instr_bound  in   1   core at safe redirect point (no stall/branch in flight)
//   eret         in   1   one-cycle pulse: core decoded return-from-interrupt
//   ie_we        in   1   software write strobe for interrupt enable
//   ie_wd        in   1   interrupt-enable write data
//   pc_redirect  out  1   core must load pc_target as next PC this cycle
//   pc_target    out  32  redirect target, word aligned
//   epc          out  32  saved return address
//   in_isr       out  1   high while handler is executing
//   ie           out  1   current interrupt enable
//   irq_count    out  CW  number of interrupts serviced, saturates at all-ones
//   eret_err     out  1   sticky: eret seen outside ISR
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; irq_ack=0, pc_redirect=0,
//     pc_target=0, epc=0, in_isr=0, ie=IE_RESET, irq_count=0, eret_err=0.
//   States IDLE -> ACK -> ISR -> RET -> IDLE. Outputs decoded from state (Moore).
//   IDLE: take when irq & ie & instr_bound at edge N: epc<=pc_next,
//     vec<={irq_addr[31:2],2'b00}, go ACK. Else stay; pending irq waits
//     indefinitely for instr_bound.
//   ACK (cycle N+1): irq_ack=1, pc_redirect=1, pc_target=vec; irq_count
//     increments at exit unless saturated; next state ISR unconditionally.
//     irq/irq_addr changes after edge N are ignored (commit is final).
//   ISR: in_isr=1; irq ignored; eret at edge M -> RET.
//   RET (cycle M+1): pc_redirect=1, pc_target=epc, in_isr=1; next IDLE.
//     A still-pending irq is evaluated in IDLE from cycle M+2 on (min one
//     IDLE cycle between handlers).
//   eret in IDLE: ignored for control, sets eret_err (cleared only by reset).
//   eret in ACK/RET: ignored, no error.
//   ie_we: ie<=ie_wd at edge; take decision in same cycle uses pre-write ie.
//   ie=0 does not abort ACK/ISR/RET already entered.
//   pc_target holds last value when pc_redirect=0.
//   Reset mid-ACK/ISR/RET: immediate return to reset values; no ack issued.
// TESTING
//   irq=1, addr=0x80, ie=1, bound=1, pc_next=0x40 -> next cycle ack=1,
//     redirect=1, target=0x80, epc=0x40; then in_isr=1, count=1.
//   irq=1 with bound=0 for 5 cycles then bound=1 -> no ack for 5 cycles,
//     ack exactly 1 cycle after bound rises, epc = pc_next at that edge.
//   In ISR assert irq again, then eret -> no second ack during ISR; RET
//     cycle target=epc; second ack 2 cycles after RET (one IDLE between).
//   ie_we=1, ie_wd=0 same cycle as irq/bound -> interrupt taken; next irq
//     with ie=0 -> never acked; irq_addr=0x83 -> target=0x80.
//   eret pulse in IDLE -> eret_err=1, no redirect; 256 services at CW=8 ->
//     irq_count stays 0xFF.
//   rst low during ISR -> all outputs at reset values, in_isr=0, ie=IE_RESET.

Source files
------------

// File: rtl/irq_sequencer.sv
// CPU-side interrupt responder: commits a pending IRQ at a safe instruction
// boundary, saves EPC, redirects fetch to the handler and returns on eret.
module irq_sequencer #(
   parameter bit IE_RESET    = 1'b1,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   irq,
   input  logic [31:0]            irq_addr,
   output logic                   irq_ack,
   input  logic [31:0]            pc_next,
   input  logic                   instr_bound,
   input  logic                   eret,
   input  logic                   ie_we,
   input  logic                   ie_wd,
   output logic                   pc_redirect,
   output logic [31:0]            pc_target,
   output logic [31:0]            epc,
   output logic                   in_isr,
   output logic                   ie,
   output logic [COUNT_WIDTH-1:0] irq_count,
   output logic                   eret_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_ISR  = 2'd2,
      ST_RET  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            epc_q, epc_d;
   logic [31:0]            target_q, target_d;
   logic                   ie_q, ie_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   err_q, err_d;
   logic                   take;

   // Decision uses the enable as it stood before any same-cycle software write.
   assign take = irq & ie_q & instr_bound;

   always_comb begin
      state_d  = state_q;
      epc_d    = epc_q;
      target_d = target_q;
      count_d  = count_q;
      err_d    = err_q;
      ie_d     = ie_we ? ie_wd : ie_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d  = ST_ACK;
               epc_d    = pc_next;
               target_d = {irq_addr[31:2], 2'b00};
            end
            if (eret) err_d = 1'b1;
         end
         ST_ACK: begin
            state_d = ST_ISR;
            if (count_q != {COUNT_WIDTH{1'b1}}) count_d = count_q + 1'b1;
         end
         ST_ISR: begin
            if (eret) begin
               state_d  = ST_RET;
               target_d = epc_q;
            end
         end
         ST_RET:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         epc_q    <= '0;
         target_q <= '0;
         ie_q     <= IE_RESET;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         epc_q    <= epc_d;
         target_q <= target_d;
         ie_q     <= ie_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // target_q is loaded on entry to ACK/RET, so it holds between redirects.
   assign irq_ack     = (state_q == ST_ACK);
   assign pc_redirect = (state_q == ST_ACK) || (state_q == ST_RET);
   assign pc_target   = target_q;
   assign epc         = epc_q;
   assign in_isr      = (state_q == ST_ISR) || (state_q == ST_RET);
   assign ie          = ie_q;
   assign irq_count   = count_q;
   assign eret_err    = err_q;

endmodule
